ercm_err_accum: RTL and testbench

Hardware error-metric accumulator that sits directly downstream of the approximate 8-bit multiplier under evaluation. Each accepted sample carries the multiplier operands and the approximate product. The block recomputes the exact product and accumulates four statistics: error count, signed error-distance sum, absolute error-distance sum, and maximum absolute error distance. A campaign of a programmed number of samples is bracketed by a start/done handshake, so host software derives ER, MED and MNED without a simulation-only bench.

---
 rtl/ercm_err_accum.sv | 127 ++++++++++++
 tb/tb_ercm_err_accum.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ercm_err_accum.sv
// ercm_err_accum: error-metric accumulator for an approximate W x W multiplier.
// Recomputes the exact product for each accepted sample, then accumulates
// error count, signed/absolute error-distance sums and the max error distance
// over a campaign of num_samples samples, bracketed by start/done.
module ercm_err_accum #(
  parameter int W   = 8,
  parameter int N_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N_W-1:0]       num_samples,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         dat_in_a,
  input  logic [W-1:0]         dat_in_b,
  input  logic [2*W-1:0]       dat_apprx,
  output logic                 busy,
  output logic                 done,
  output logic [N_W-1:0]       samp_cnt,
  output logic [N_W-1:0]       err_cnt,
  output logic [N_W+2*W:0]     sum_ed,
  output logic [N_W+2*W-1:0]   sum_ed_abs,
  output logic [2*W-1:0]       max_ed
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Stage-1 payload: exact product alongside the multiplier's approximation.
  typedef struct packed {
    logic [2*W-1:0] exact;
    logic [2*W-1:0] apprx;
  } s1_t;

  state_t         state, state_nxt;
  logic [N_W-1:0] num_lat;
  logic [N_W-1:0] samp_nxt;
  logic           accept, start_acc, last_acc;
  s1_t            s1;
  logic           s1_valid;
  logic [2*W:0]   ed;
  logic [2*W:0]   ed_neg;
  logic [2*W-1:0] ed_abs;

  assign in_ready  = (state == RUN);
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign start_acc = start & (state == IDLE);
  assign samp_nxt  = samp_cnt + {{(N_W-1){1'b0}}, 1'b1};
  // The sample that brings the count up to the programmed total closes RUN.
  assign last_acc  = accept & (samp_nxt == num_lat);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: RUN until the last sample, one DRAIN cycle for stage 2,
  // then a single DONE cycle. A zero-length campaign goes straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (num_samples == '0) ? DONE : RUN;
      RUN:   if (last_acc) state_nxt = DRAIN;
      DRAIN: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Campaign length latch and accepted-sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_lat  <= '0;
      samp_cnt <= '0;
    end else if (start_acc) begin
      num_lat  <= num_samples;
      samp_cnt <= '0;
    end else if (accept) begin
      samp_cnt <= samp_nxt;
    end
  end

  // Stage 1: exact product and approximate product captured together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1.exact <= {{W{1'b0}}, dat_in_a} * {{W{1'b0}}, dat_in_b};
        s1.apprx <= dat_apprx;
      end
    end
  end

  // Error distance at 2W+1 bits so the sign survives; magnitude fits in 2W.
  always_comb begin
    ed     = {1'b0, s1.exact} - {1'b0, s1.apprx};
    ed_neg = '0 - ed;
    ed_abs = ed[2*W] ? ed_neg[2*W-1:0] : ed[2*W-1:0];
  end

  // Stage 2: statistics, cleared by an accepted start and held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt    <= '0;
      sum_ed     <= '0;
      sum_ed_abs <= '0;
      max_ed     <= '0;
    end else if (start_acc) begin
      err_cnt    <= '0;
      sum_ed     <= '0;
      sum_ed_abs <= '0;
      max_ed     <= '0;
    end else if (s1_valid) begin
      sum_ed     <= sum_ed + {{N_W{ed[2*W]}}, ed};
      sum_ed_abs <= sum_ed_abs + {{N_W{1'b0}}, ed_abs};
      if (ed != '0)       err_cnt <= err_cnt + {{(N_W-1){1'b0}}, 1'b1};
      if (ed_abs > max_ed) max_ed <= ed_abs;
    end
  end

endmodule

// File: tb/tb_ercm_err_accum.sv
// Directed bench for ercm_err_accum: hand-computed vectors, immediate asserts.
module tb_ercm_err_accum;

  localparam int W   = 8;
  localparam int N_W = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [N_W-1:0]     num_samples;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       dat_in_a;
  logic [W-1:0]       dat_in_b;
  logic [2*W-1:0]     dat_apprx;
  logic               busy;
  logic               done;
  logic [N_W-1:0]     samp_cnt;
  logic [N_W-1:0]     err_cnt;
  logic [N_W+2*W:0]   sum_ed;
  logic [N_W+2*W-1:0] sum_ed_abs;
  logic [2*W-1:0]     max_ed;

  int n_tests = 0;
  int n_fail  = 0;

  ercm_err_accum #(.W(W), .N_W(N_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .dat_in_a(dat_in_a),
    .dat_in_b(dat_in_b), .dat_apprx(dat_apprx), .busy(busy), .done(done),
    .samp_cnt(samp_cnt), .err_cnt(err_cnt), .sum_ed(sum_ed),
    .sum_ed_abs(sum_ed_abs), .max_ed(max_ed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Statistics snapshot: samp, err, signed sum (33-bit pattern), abs sum, max.
  task automatic chk_stats(input string tag, input logic [63:0] s, input logic [63:0] e,
                           input logic [63:0] se, input logic [63:0] sa, input logic [63:0] mx);
    chk({tag, ".samp_cnt"},   64'(samp_cnt),   s);
    chk({tag, ".err_cnt"},    64'(err_cnt),    e);
    chk({tag, ".sum_ed"},     64'(sum_ed),     se);
    chk({tag, ".sum_ed_abs"}, 64'(sum_ed_abs), sa);
    chk({tag, ".max_ed"},     64'(max_ed),     mx);
  endtask

  // Pulse start for one cycle; returns in the cycle after the start edge.
  task automatic do_start(input logic [N_W-1:0] n);
    start = 1'b1; num_samples = n;
    @(negedge clk);
    start = 1'b0; num_samples = '0;
  endtask

  // One-cycle sample; returns in the cycle after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] p);
    in_valid = 1'b1; dat_in_a = a; dat_in_b = b; dat_apprx = p;
    @(negedge clk);
    in_valid = 1'b0; dat_in_a = '0; dat_in_b = '0; dat_apprx = '0;
  endtask

  // Called in the cycle after the last accept: done must come one cycle later.
  task automatic wait_done(input string tag);
    int cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done) break;
    end
    chk({tag, ".done_lat"}, 64'(cyc), 64'd1);
  endtask

  // After done: it must drop, and the block returns to idle.
  task automatic chk_after_done(input string tag);
    @(negedge clk);
    chk({tag, ".done_drop"}, 64'(done),     64'd0);
    chk({tag, ".idle_busy"}, 64'(busy),     64'd0);
    chk({tag, ".idle_rdy"},  64'(in_ready), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    dat_in_a = '0; dat_in_b = '0; dat_apprx = '0;
    repeat (2) @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.busy",     64'(busy),     64'd0);
    chk("rst.done",     64'(done),     64'd0);
    chk_stats("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Exact match, single sample.
    do_start(16'd1);
    chk("t1.in_ready", 64'(in_ready), 64'd1);
    chk("t1.busy",     64'(busy),     64'd1);
    chk_stats("t1.start", 0, 0, 0, 0, 0);
    send(8'd3, 8'd5, 16'd15);
    chk("t1.drain_busy", 64'(busy),     64'd1);
    chk("t1.drain_rdy",  64'(in_ready), 64'd0);
    wait_done("t1");
    chk_stats("t1", 1, 0, 0, 0, 0);
    chk_after_done("t1");

    // Signed errors cancel in sum_ed but not in sum_ed_abs.
    do_start(16'd2);
    send(8'd255, 8'd255, 16'd65024);
    send(8'd255, 8'd255, 16'd65026);
    wait_done("t2");
    chk_stats("t2", 2, 2, 0, 2, 1);
    chk_after_done("t2");

    // Max tracking with 3-cycle gaps.
    do_start(16'd3);
    send(8'd16, 8'd16, 16'd200);
    repeat (3) @(negedge clk);
    chk("t3.gap_rdy", 64'(in_ready), 64'd1);
    chk_stats("t3.mid", 1, 1, 56, 56, 56);
    send(8'd10, 8'd10, 16'd100);
    repeat (3) @(negedge clk);
    send(8'd128, 8'd2, 16'd0);
    wait_done("t3");
    chk_stats("t3", 3, 2, 312, 312, 256);
    chk_after_done("t3");
    // Results hold in IDLE, and in_valid there is ignored.
    send(8'd1, 8'd1, 16'd9);
    @(negedge clk);
    chk_stats("t3.hold", 3, 2, 312, 312, 256);

    // Zero-length campaign, then a normal one with a negative error.
    do_start(16'd0);
    chk("t4.done",     64'(done),     64'd1);
    chk("t4.in_ready", 64'(in_ready), 64'd0);
    chk("t4.busy",     64'(busy),     64'd0);
    chk_stats("t4.zero", 0, 0, 0, 0, 0);
    chk_after_done("t4");
    do_start(16'd1);
    send(8'd7, 8'd9, 16'd70);
    wait_done("t4b");
    chk_stats("t4b", 1, 1, 64'h1_FFFF_FFF9, 7, 7);
    chk_after_done("t4b");

    // start during RUN is ignored.
    do_start(16'd5);
    send(8'd100, 8'd2, 16'd190);
    send(8'd1, 8'd1, 16'd3);
    do_start(16'd1);
    chk("t5.still_run", 64'(in_ready), 64'd1);
    chk_stats("t5.mid", 2, 2, 8, 12, 10);
    send(8'd2, 8'd2, 16'd4);
    send(8'd2, 8'd2, 16'd4);
    chk("t5.not_done", 64'(in_ready), 64'd1);
    send(8'd2, 8'd2, 16'd4);
    wait_done("t5");
    chk_stats("t5", 5, 2, 8, 12, 10);
    chk_after_done("t5");

    // Reset mid-campaign, with a sample in flight in stage 1.
    do_start(16'd4);
    send(8'd50, 8'd50, 16'd0);
    in_valid = 1'b1; dat_in_a = 8'd40; dat_in_b = 8'd40; dat_apprx = 16'd0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6.rst_rdy",  64'(in_ready), 64'd0);
    chk("t6.rst_busy", 64'(busy),     64'd0);
    chk("t6.rst_done", 64'(done),     64'd0);
    chk_stats("t6.rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_stats("t6.post", 0, 0, 0, 0, 0);
    chk("t6.idle_rdy", 64'(in_ready), 64'd0);
    do_start(16'd1);
    send(8'd2, 8'd3, 16'd5);
    wait_done("t6");
    chk_stats("t6", 1, 1, 1, 1, 1);
    chk_after_done("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
